// File: rtl/challenge_auth_responder_pkg.sv
// Shared constants, field widths and state encoding for the authentication responders.
package challenge_auth_responder_pkg;

    localparam logic [7:0] PROTOCOL_VERSION   = 8'h01;
    localparam logic [7:0] CHALLENGE_CMD      = 8'h83;
    localparam logic [7:0] CHALLENGE_AUTH_CMD = 8'h03;
    localparam logic [7:0] ERROR_CMD          = 8'h7F;

    localparam logic [7:0] ERR_INVALID           = 8'h01;
    localparam logic [7:0] ERR_UNSUPPORTED_PROTO = 8'h02;
    localparam logic [7:0] ERR_UNSPECIFIED       = 8'h04;

    localparam int HEADER_W = 32;
    localparam int NONCE_W  = 256;
    localparam int HASH_W   = 256;
    localparam int REQ_W    = HEADER_W + NONCE_W;
    localparam int MSG_W    = 2 * HEADER_W + HASH_W + NONCE_W;

    localparam logic [7:0] AUTH_MSG_BYTES = 8'd72;
    localparam logic [7:0] ERR_MSG_BYTES  = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_HASH_WAIT = 3'd2,
        ST_SEND      = 3'd3,
        ST_ERR_SEND  = 3'd4
    } state_t;

    // Error message sits in the top bytes; the remainder is zero padding.
    function automatic logic [MSG_W-1:0] error_msg(input logic [7:0] ver, input logic [7:0] code);
        return {ver, ERROR_CMD, code, 8'h00, {(MSG_W - HEADER_W){1'b0}}};
    endfunction

endpackage

// File: rtl/challenge_auth_responder_serializer.sv
// Generic message serializer: loads a 576-bit buffer and streams it MSB-first in DATA_W beats.
module auth_msg_serializer
    import challenge_auth_responder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              abort,
    input  logic              load,
    input  logic [MSG_W-1:0]  load_data,
    input  logic [7:0]        load_len,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_last
);

    localparam int BEAT_BYTES = DATA_W / 8;

    logic [MSG_W-1:0] msg_q;
    logic [7:0]       beats_left;
    logic [7:0]       load_beats;

    always_comb begin
        load_beats = 8'((int'(load_len) + BEAT_BYTES - 1) / BEAT_BYTES);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_q      <= '0;
            beats_left <= '0;
        end else if (abort) begin
            msg_q      <= '0;
            beats_left <= '0;
        end else if (load) begin
            msg_q      <= load_data;
            beats_left <= load_beats;
        end else if (tx_valid && tx_ready) begin
            msg_q      <= msg_q << DATA_W;
            beats_left <= beats_left - 8'd1;
        end
    end

    assign tx_valid = (beats_left != 8'd0);
    assign tx_data  = msg_q[MSG_W-1 -: DATA_W];
    assign tx_last  = (beats_left == 8'd1);

endmodule

// File: rtl/challenge_auth_responder.sv
// CHALLENGE responder: validates a request, fetches the slot hash, streams CHALLENGE_AUTH or ERROR.
//
// state        | meaning
// IDLE         | ready for a request (req_ready = enable)
// CHECK        | validate version, type, slot and nonce of the captured request
// HASH_WAIT    | hash_req held for the slot hash, bounded by the timeout counter
// SEND         | streaming the 72-byte CHALLENGE_AUTH message
// ERR_SEND     | streaming the 4-byte ERROR message
module challenge_auth_responder
    import challenge_auth_responder_pkg::*;
#(
    parameter int         NUM_SLOTS      = 8,
    parameter int         DATA_W         = 32,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] PROTO_VER      = PROTOCOL_VERSION
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [REQ_W-1:0]     req_msg,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    input  logic [7:0]           capabilities,
    output logic                 hash_req,
    output logic [7:0]           hash_slot,
    input  logic                 hash_ack,
    input  logic [HASH_W-1:0]    hash_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_last,
    output logic                 tx_is_error,
    output logic                 err_pulse,
    output logic [7:0]           err_code,
    output logic                 busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_nxt;

    logic [7:0]         ver_q, type_q, slot_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [7:0]         mask8;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               check_fail;
    logic [7:0]         check_code;
    logic               hash_timeout;
    logic               tx_done;
    logic               err_set;
    logic [7:0]         err_set_code;
    logic               ser_load;
    logic [MSG_W-1:0]   ser_data;
    logic [7:0]         ser_len;
    logic               tx_is_error_q, err_pulse_q;
    logic [7:0]         err_code_q;
    logic               unused_param2;

    assign unused_param2 = ^req_msg[263:256];

    always_comb begin
        mask8 = '0;
        mask8[NUM_SLOTS-1:0] = slot_mask;
    end

    always_comb begin
        check_fail = 1'b1;
        check_code = ERR_INVALID;
        if (ver_q != PROTO_VER)
            check_code = ERR_UNSUPPORTED_PROTO;
        else if (type_q != CHALLENGE_CMD)
            check_code = ERR_INVALID;
        else if (slot_q >= 8'(NUM_SLOTS) || !mask8[slot_q[2:0]])
            check_code = ERR_INVALID;
        else if (nonce_q == '0)
            check_code = ERR_INVALID;
        else
            check_fail = 1'b0;
    end

    assign hash_timeout = (state == ST_HASH_WAIT) && !hash_ack && (tmo_cnt == '0);
    assign tx_done      = tx_valid && tx_ready && tx_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (req_valid) state_nxt = ST_CHECK;
                ST_CHECK:     state_nxt = check_fail ? ST_ERR_SEND : ST_HASH_WAIT;
                ST_HASH_WAIT: begin
                    if (hash_ack)
                        state_nxt = ST_SEND;
                    else if (hash_timeout)
                        state_nxt = ST_ERR_SEND;
                end
                ST_SEND,
                ST_ERR_SEND:  if (tx_done) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // The serializer is loaded on the transition edge, so the first beat is valid in the first SEND cycle.
    always_comb begin
        ser_load     = 1'b0;
        ser_data     = '0;
        ser_len      = '0;
        err_set      = 1'b0;
        err_set_code = '0;
        if (enable) begin
            case (state)
                ST_CHECK: begin
                    if (check_fail) begin
                        err_set      = 1'b1;
                        err_set_code = check_code;
                    end
                end
                ST_HASH_WAIT: begin
                    if (hash_ack) begin
                        ser_load = 1'b1;
                        ser_data = {PROTO_VER, CHALLENGE_AUTH_CMD, slot_q, mask8,
                                    PROTO_VER, PROTO_VER, capabilities, 8'h00,
                                    hash_data, nonce_q};
                        ser_len  = AUTH_MSG_BYTES;
                    end else if (hash_timeout) begin
                        err_set      = 1'b1;
                        err_set_code = ERR_UNSPECIFIED;
                    end
                end
                default: ;
            endcase
        end
        if (err_set) begin
            ser_load = 1'b1;
            ser_data = error_msg(PROTO_VER, err_set_code);
            ser_len  = ERR_MSG_BYTES;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ver_q         <= '0;
            type_q        <= '0;
            slot_q        <= '0;
            nonce_q       <= '0;
            tmo_cnt       <= '0;
            tx_is_error_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            if (req_valid && req_ready) begin
                ver_q   <= req_msg[287:280];
                type_q  <= req_msg[279:272];
                slot_q  <= req_msg[271:264];
                nonce_q <= req_msg[255:0];
            end
            if (state != ST_HASH_WAIT)
                tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            if (!enable || tx_done)
                tx_is_error_q <= 1'b0;
            else if (ser_load)
                tx_is_error_q <= err_set;
            err_pulse_q <= err_set;
            if (err_set)
                err_code_q <= err_set_code;
        end
    end

    auth_msg_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (!enable),
        .load      (ser_load),
        .load_data (ser_data),
        .load_len  (ser_len),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last)
    );

    assign req_ready   = (state == ST_IDLE) && enable;
    assign hash_req    = (state == ST_HASH_WAIT);
    assign hash_slot   = slot_q;
    assign tx_is_error = tx_is_error_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign busy        = (state != ST_IDLE);

endmodule
